// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/operand request and busy/done/result bundle for serial_adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder, one full-adder cell and one carry flop
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, ADD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             done_q, done_d;
  logic             s_bit;
  logic             c_next;

  assign s_bit  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign c_next = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    psum_d      = psum_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ADD;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          psum_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ADD: begin
        a_sr_d            = a_sr_q >> 1;
        b_sr_d            = b_sr_q >> 1;
        psum_d            = psum_q >> 1;
        psum_d[WIDTH-1]   = s_bit;
        carry_d           = c_next;
        cnt_d             = cnt_q + CW'(1);
        // Last bit: publish the freshly completed partial sum, not the stale register.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = IDLE;
          sum_d       = psum_d;
          carry_out_d = c_next;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      psum_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      psum_q      <= psum_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q == ADD);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed scoreboard bench for serial_adder at WIDTH 8 and 1
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [7:0] prev_sum;
  logic       prev_cout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result scoreboards: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus8.done) begin
      chk("done8_has_request", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) chk("result8", {bus8.carry_out, bus8.sum}, q8.pop_front());
    end
    if (bus1.done) begin
      chk("done1_has_request", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) chk("result1", {bus1.carry_out, bus1.sum}, q1.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the done cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit toggle);
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b};
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    @(posedge clk);
    q8.push_back(exp);
    #1 bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (toggle) begin
        bus8.a = ~bus8.a;
        bus8.b = ~bus8.b;
        bus8.start = i[0];
      end
      @(negedge clk);
      chk("busy_phase", {bus8.busy, bus8.done, bus8.carry_out, bus8.sum},
          {1'b1, 1'b0, prev_cout, prev_sum});
      @(posedge clk);
      #1;
    end
    bus8.start = 1'b0;
    @(negedge clk);
    chk("done_phase", {bus8.busy, bus8.done, bus8.carry_out, bus8.sum}, {1'b0, 1'b1, exp});
    prev_sum  = exp[7:0];
    prev_cout = exp[8];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    prev_sum = '0;
    prev_cout = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_async8", {bus8.busy, bus8.done, bus8.carry_out, bus8.sum}, 32'd0);
    chk("reset_async1", {bus1.busy, bus1.done, bus1.carry_out, bus1.sum}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1);

    // start held for 20 edges: accepts at 0, 9 and 18, completes at 8, 17 and 26
    bus8.a = 8'h03;
    bus8.b = 8'h04;
    bus8.start = 1'b1;
    for (int cyc = 0; cyc < 27; cyc++) begin
      @(posedge clk);
      if (cyc < 20 && (cyc % 9) == 0) q8.push_back(9'h007);
      #1;
      if (cyc == 19) bus8.start = 1'b0;
      @(negedge clk);
      chk("b2b_done", {bus8.done, bus8.busy},
          {1'(cyc == 8 || cyc == 17 || cyc == 26), 1'(cyc != 8 && cyc != 17 && cyc != 26)});
    end
    @(posedge clk);
    #1;
    prev_sum  = 8'h07;
    prev_cout = 1'b0;

    // Abort mid-addition; no result may be produced for this request.
    bus8.a = 8'h55;
    bus8.b = 8'h0F;
    bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_add", {bus8.busy, bus8.done, bus8.carry_out, bus8.sum}, 32'd0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    @(negedge clk);
    chk("reset_held", {bus8.busy, bus8.done}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b0);

    bus1.a = 1'b1;
    bus1.b = 1'b1;
    bus1.start = 1'b1;
    @(posedge clk);
    q1.push_back(2'b10);
    #1 bus1.start = 1'b0;
    @(negedge clk);
    chk("w1_busy", {bus1.busy, bus1.done, bus1.carry_out, bus1.sum}, {1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk("w1_done", {bus1.busy, bus1.done, bus1.carry_out, bus1.sum}, {1'b0, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    bus1.a = 1'b1;
    bus1.b = 1'b0;
    bus1.start = 1'b1;
    @(posedge clk);
    q1.push_back(2'b01);
    #1 bus1.start = 1'b0;
    @(negedge clk);
    chk("w1_busy2", {bus1.busy, bus1.done, bus1.carry_out, bus1.sum}, {1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk("w1_done2", {bus1.busy, bus1.done, bus1.carry_out, bus1.sum}, {1'b0, 1'b1, 1'b0, 1'b1});
    repeat (3) @(posedge clk);
    #1;

    chk("sb8_drained", 32'(q8.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
